regfile_mp: RTL



---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 115 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned ZERO_REG  = 0;
    localparam int unsigned MAX_WR    = 16;

    // Winning write port for one address: highest-index port whose hit bit is set.
    function automatic int unsigned win_port(input logic [MAX_WR-1:0] hit);
        int unsigned w;
        w = 0;
        for (int unsigned p = 0; p < MAX_WR; p++) begin
            if (hit[p]) w = p;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, alloc sets, write clears.
// RF_BYPASS_EN exports the next-state pending vector for same-cycle busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    output logic [NREGS-1:0]    o_busy_mask
`ifdef RF_BYPASS_EN
   ,output logic [NREGS-1:0]    o_pend_nxt_c
`endif
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // Alloc is applied after the write clears so a new producer keeps the bit set.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
                w_pend_nxt[i_wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (i_alloc_en && (i_alloc_addr != AW'(ZERO_REG))) begin
            w_pend_nxt[i_alloc_addr] = 1'b1;
        end
        w_pend_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign o_busy_mask = r_pend;
`ifdef RF_BYPASS_EN
    assign o_pend_nxt_c = w_pend_nxt;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and pending-write scoreboard.
// RF_BYPASS_EN: same-cycle write data and next-state busy are forwarded to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREGS-1:0]    busy_mask
);

    logic [XLEN-1:0]     r_mem [NREGS];
    logic [NRD*XLEN-1:0] r_rd_data;
    logic [NRD-1:0]      r_rd_busy;

    logic [NREGS-1:0]    w_we;
    logic [XLEN-1:0]     w_wd [NREGS];
    logic [XLEN-1:0]     w_rd_val [NRD];
    logic [NRD-1:0]      w_rd_busy;
    logic [NREGS-1:0]    w_busy_mask;
`ifdef RF_BYPASS_EN
    logic [NREGS-1:0]    w_pend_nxt;
`endif

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_alloc_en   (alloc_en),
        .i_alloc_addr (alloc_addr),
        .o_busy_mask  (w_busy_mask)
`ifdef RF_BYPASS_EN
       ,.o_pend_nxt_c (w_pend_nxt)
`endif
    );

    // Per-register write enable and winning data.
    always_comb begin
        logic [MAX_WR-1:0] hit;
        for (int unsigned a = 0; a < NREGS; a++) begin
            hit = '0;
            for (int unsigned p = 0; p < NWR; p++) begin
                hit[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(a)) && (a != ZERO_REG);
            end
            w_we[a] = |hit;
            w_wd[a] = wr_data[win_port(hit)*XLEN +: XLEN];
        end
    end

    // Read value and busy selection per read port.
    always_comb begin
`ifdef RF_BYPASS_EN
        logic [MAX_WR-1:0] hit;
`endif
        w_rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
`ifdef RF_BYPASS_EN
            hit = '0;
            for (int unsigned p = 0; p < NWR; p++) begin
                hit[p] = wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])
                         && (rd_addr[i*AW +: AW] != AW'(ZERO_REG));
            end
            w_rd_val[i]  = (|hit) ? wr_data[win_port(hit)*XLEN +: XLEN]
                                  : r_mem[rd_addr[i*AW +: AW]];
            w_rd_busy[i] = w_pend_nxt[rd_addr[i*AW +: AW]];
`else
            w_rd_val[i]  = r_mem[rd_addr[i*AW +: AW]];
            w_rd_busy[i] = w_busy_mask[rd_addr[i*AW +: AW]];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                r_mem[a] <= '0;
            end
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            for (int unsigned a = 1; a < NREGS; a++) begin
                if (w_we[a]) r_mem[a] <= w_wd[a];
            end
            for (int unsigned i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    r_rd_data[i*XLEN +: XLEN] <= w_rd_val[i];
                    r_rd_busy[i]              <= w_rd_busy[i];
                end
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_busy   = r_rd_busy;
    assign busy_mask = w_busy_mask;

endmodule
